// File: rtl/memory_stage_if.sv
// memory_stage_if: execute-to-memory bus carrying instruction, operands, read data and status
// master drives opcode/instr_valid/imem_error/valE/valA/valP; slave returns valM/stat/halted
interface memory_stage_if #(parameter int ADDR_W = 64);
  logic [7:0] opcode;
  logic instr_valid;
  logic imem_error;
  logic [ADDR_W-1:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic [63:0] valM;
  logic [2:0] stat;
  logic halted;
  modport master(output opcode, instr_valid, imem_error, valE, valA, valP, input valM, stat, halted);
  modport slave(input opcode, instr_valid, imem_error, valE, valA, valP, output valM, stat, halted);
endinterface

// File: rtl/memory_stage.sv
// memory_stage: Y86-64 SEQ memory stage with little-endian data memory, status and sticky halt
// Ports: clk, rst_n (async active-low), bus (slave: opcode, instr_valid, imem_error,
// valE, valA, valP in; valM, stat, halted out)
module memory_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W = 64
) (
  input logic clk,
  input logic rst_n,
  memory_stage_if.slave bus
);
  localparam int IW = $clog2(MEM_BYTES);
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  logic [7:0] mem [MEM_BYTES];
  logic [3:0] icode;
  logic is_rd, is_wr, legal, we, halted;
  logic [ADDR_W-1:0] addr;
  logic [IW-1:0] base;
  logic [63:0] rdq, wdata;
  logic [2:0] cur_stat, lat_stat;
  assign icode = bus.opcode[7:4];
  assign is_rd = icode == 4'h5 || icode == 4'h9 || icode == 4'hB;
  assign is_wr = icode == 4'h4 || icode == 4'h8 || icode == 4'hA;
  // ret/popq address the stack through valA; everything else uses valE
  assign addr = (icode == 4'h9 || icode == 4'hB) ? bus.valA : bus.valE;
  // full-width unsigned compare so addresses near 2^64 cannot wrap into range
  assign legal = addr <= ADDR_W'(MEM_BYTES - 8);
  assign base = addr[IW-1:0];
  assign wdata = icode == 4'h8 ? bus.valP : bus.valA;
  assign cur_stat = bus.imem_error ? ADR :
                    !bus.instr_valid ? INS :
                    icode == 4'h0 ? HLT :
                    ((is_rd || is_wr) && !legal) ? ADR : AOK;
  assign we = is_wr && legal && cur_stat == AOK && !halted;
  always_comb begin
    rdq = '0;
    for (int i = 0; i < 8; i++) rdq[8*i +: 8] = mem[base + IW'(i)];
  end
  assign bus.valM = (is_rd && legal) ? rdq : '0;
  assign bus.stat = halted ? lat_stat : cur_stat;
  assign bus.halted = halted;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < 8; i++) mem[base + IW'(i)] <= wdata[8*i +: 8];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
      lat_stat <= AOK;
    end else if (!halted && cur_stat != AOK) begin
      halted <= 1'b1;
      lat_stat <= cur_stat;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage with directed and random stimulus
module tb_memory_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  memory_stage_if bus();
  memory_stage dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [63:0] valm;
    logic [2:0] st;
    logic h;
    string name;
  } exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] mm [1024];
  bit m_halted;
  logic [2:0] m_lstat;
  function automatic void chk(string n, string f, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", n, f, act, exp);
    end
  endfunction
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk(x.name, "valM", bus.valM, x.valm);
      chk(x.name, "stat", 64'(bus.stat), 64'(x.st));
      chk(x.name, "halted", 64'(bus.halted), 64'(x.h));
    end
  end
  function automatic void m_reset();
    foreach (mm[i]) mm[i] = 8'h00;
    m_halted = 1'b0;
    m_lstat = 3'd1;
  endfunction
  function automatic logic [2:0] ref_stat(int ic, bit iv, bit ie, logic [63:0] ad);
    if (ie) return 3'd3;
    if (!iv) return 3'd4;
    if (ic == 0) return 3'd2;
    if (ic inside {4, 5, 8, 9, 10, 11} && ad > 64'd1016) return 3'd3;
    return 3'd1;
  endfunction
  task automatic drive(logic [7:0] op, bit iv, bit ie, logic [63:0] e, logic [63:0] a, logic [63:0] p);
    bus.opcode = op;
    bus.instr_valid = iv;
    bus.imem_error = ie;
    bus.valE = e;
    bus.valA = a;
    bus.valP = p;
  endtask
  task automatic step(string nm, logic [7:0] op, bit iv, bit ie, logic [63:0] e, logic [63:0] a, logic [63:0] p);
    logic [63:0] ad, rv, wd;
    logic [2:0] cs;
    int ic;
    exp_t x;
    @(posedge clk);
    #1;
    drive(op, iv, ie, e, a, p);
    ic = int'(op[7:4]);
    ad = (ic == 9 || ic == 11) ? a : e;
    cs = ref_stat(ic, iv, ie, ad);
    rv = 64'd0;
    if (ic inside {5, 9, 11} && ad <= 64'd1016)
      for (int i = 0; i < 8; i++) rv[8*i +: 8] = mm[int'(ad) + i];
    x.valm = rv;
    x.st = m_halted ? m_lstat : cs;
    x.h = m_halted;
    x.name = nm;
    q.push_back(x);
    if (rst_n) begin
      if (ic inside {4, 8, 10} && ad <= 64'd1016 && cs == 3'd1 && !m_halted) begin
        wd = (ic == 8) ? p : a;
        for (int i = 0; i < 8; i++) mm[int'(ad) + i] = wd[8*i +: 8];
      end
      if (!m_halted && cs != 3'd1) begin
        m_halted = 1'b1;
        m_lstat = cs;
      end
    end
  endtask
  task automatic do_reset();
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(8'h10, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
    m_reset();
    x.valm = 64'd0;
    x.st = 3'd1;
    x.h = 1'b0;
    x.name = "reset";
    q.push_back(x);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  function automatic logic [63:0] rand_addr();
    int r;
    r = int'($urandom % 100);
    if (r < 8) return {$urandom, $urandom} | 64'hFFFF_0000_0000_0000;
    if (r < 25) return 64'($urandom_range(1000, 1023));
    return 64'($urandom % 256);
  endfunction
  initial begin
    exp_t x;
    logic [3:0] ic;
    drive(8'h10, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
    m_reset();
    do_reset();
    step("st16", 8'h40, 1, 0, 64'd16, 64'h1122334455667788, 64'd0);
    step("ld16", 8'h50, 1, 0, 64'd16, 64'd0, 64'd0);
    step("ld9", 8'h50, 1, 0, 64'd9, 64'd0, 64'd0);
    step("call", 8'h80, 1, 0, 64'd120, 64'd0, 64'h2A);
    step("ret", 8'h90, 1, 0, 64'd0, 64'd120, 64'd0);
    step("pop", 8'hB0, 1, 0, 64'd0, 64'd120, 64'd0);
    step("st1016", 8'h40, 1, 0, 64'd1016, 64'hCAFE_F00D_1234_5678, 64'd0);
    step("ld1016", 8'h50, 1, 0, 64'd1016, 64'd0, 64'd0);
    step("st1017", 8'h40, 1, 0, 64'd1017, 64'hDEAD, 64'd0);
    step("ld_huge", 8'h50, 1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0);
    step("ld1016_halted", 8'h50, 1, 0, 64'd1016, 64'd0, 64'd0);
    do_reset();
    step("halt", 8'h00, 1, 0, 64'd0, 64'd0, 64'd0);
    step("st0_halted", 8'h40, 1, 0, 64'd0, 64'd5, 64'd0);
    do_reset();
    step("ld0", 8'h50, 1, 0, 64'd0, 64'd0, 64'd0);
    step("prio_adr", 8'h00, 0, 1, 64'd0, 64'd0, 64'd0);
    do_reset();
    step("prio_ins", 8'h00, 0, 0, 64'd0, 64'd0, 64'd0);
    do_reset();
    step("push8", 8'hA0, 1, 0, 64'd8, 64'd9, 64'd0);
    step("ld8", 8'h50, 1, 0, 64'd8, 64'd0, 64'd0);
    step("halt2", 8'h00, 1, 0, 64'd0, 64'd0, 64'd0);
    @(posedge clk);
    #1;
    drive(8'hA0, 1'b1, 1'b0, 64'd8, 64'd7, 64'd0);
    #2;
    rst_n = 1'b0;
    m_reset();
    x.valm = 64'd0;
    x.st = 3'd1;
    x.h = 1'b0;
    x.name = "mid_reset";
    q.push_back(x);
    step("ld8_in_reset", 8'h50, 1, 0, 64'd8, 64'd0, 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step("ld8_after", 8'h50, 1, 0, 64'd8, 64'd0, 64'd0);
    for (int n = 0; n < 400; n++) begin
      if (m_halted && ($urandom % 3 == 0)) do_reset();
      ic = ($urandom % 100 < 2) ? 4'h0 : 4'(1 + $urandom % 11);
      step("rand", {ic, 4'h0}, ($urandom % 50) != 0, ($urandom % 80) == 0, rand_addr(),
           ($urandom % 2) ? rand_addr() : {$urandom, $urandom}, {$urandom, $urandom});
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
